// File: rtl/rvfi_pkg.sv
// Shared types and constants for the RVFI retirement packer.
// Issue-side queue entries and the registered retirement packet.
package rvfi_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN = 32;
    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    typedef struct packed {
        logic [XLEN-1:0]       insn;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [XLEN-1:0]       rs1_rdata;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [XLEN-1:0]       rs2_rdata;
    } issue_entry_t;

    typedef struct packed {
        logic [XLEN-1:0]       insn;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [XLEN-1:0]       rs1_rdata;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [XLEN-1:0]       rs2_rdata;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       rd_wdata;
    } rvfi_pkt_t;

    // x0 always reads as zero and never holds a written value.
    function automatic logic [XLEN-1:0] mask_x0(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [XLEN-1:0]       data
    );
        return (addr == X0) ? '0 : data;
    endfunction

endpackage

// File: rtl/rvfi_issue_fifo.sv
// Queue of issued-but-not-retired instructions.
// Clear squashes everything, including a same-cycle push.
module rvfi_issue_fifo
    import rvfi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  issue_entry_t               data_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output issue_entry_t               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    issue_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !clear_i && (!full_o || do_pop);

    // Next pointers and occupancy; clear empties the queue after the pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rvfi_retire_packer.sv
// Pairs issue-time operand reads with writeback results in program
// order and emits one registered RVFI packet per retirement.
module rvfi_retire_packer
    import rvfi_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ORDER_W = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   id_valid_i,
    input  logic [31:0]            id_insn_i,
    input  logic [4:0]             id_rs1_addr_i,
    input  logic [31:0]            id_rs1_rdata_i,
    input  logic [4:0]             id_rs2_addr_i,
    input  logic [31:0]            id_rs2_rdata_i,
    input  logic                   wb_valid_i,
    input  logic [4:0]             wb_rd_addr_i,
    input  logic [31:0]            wb_rd_wdata_i,
    input  logic                   flush_i,
    output logic                   rvfi_valid,
    output logic [ORDER_W-1:0]     rvfi_order,
    output logic [31:0]            rvfi_insn,
    output logic [4:0]             rvfi_rs1_addr,
    output logic [31:0]            rvfi_rs1_rdata,
    output logic [4:0]             rvfi_rs2_addr,
    output logic [31:0]            rvfi_rs2_rdata,
    output logic [4:0]             rvfi_rd_addr,
    output logic [31:0]            rvfi_rd_wdata,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic                   err_overflow_o,
    output logic                   err_underflow_o
);

    issue_entry_t       entry_in;
    issue_entry_t       head;
    rvfi_pkt_t          pkt_d, pkt_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               ovf_set;
    logic               unf_set;
    logic               valid_q;
    logic [ORDER_W-1:0] order_q;
    logic [ORDER_W-1:0] cnt_q;
    logic               ovf_q;
    logic               unf_q;

    assign entry_in = '{
        insn:      id_insn_i,
        rs1_addr:  id_rs1_addr_i,
        rs1_rdata: id_rs1_rdata_i,
        rs2_addr:  id_rs2_addr_i,
        rs2_rdata: id_rs2_rdata_i
    };

    // Only entries already queued at the start of the cycle can retire.
    assign pop     = wb_valid_i && !fifo_empty;
    assign unf_set = wb_valid_i && fifo_empty;
    assign ovf_set = id_valid_i && !flush_i && fifo_full && !pop;

    rvfi_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (id_valid_i),
        .data_i  (entry_in),
        .pop_i   (pop),
        .clear_i (flush_i),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occupancy_o)
    );

    // Assemble the retiring packet with x0 reads/writes forced to zero.
    always_comb begin
        pkt_d           = '0;
        pkt_d.insn      = head.insn;
        pkt_d.rs1_addr  = head.rs1_addr;
        pkt_d.rs1_rdata = mask_x0(head.rs1_addr, head.rs1_rdata);
        pkt_d.rs2_addr  = head.rs2_addr;
        pkt_d.rs2_rdata = mask_x0(head.rs2_addr, head.rs2_rdata);
        pkt_d.rd_addr   = wb_rd_addr_i;
        pkt_d.rd_wdata  = mask_x0(wb_rd_addr_i, wb_rd_wdata_i);
    end

    // Output register, order counter and sticky error flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
            order_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            valid_q <= pop;
            if (pop) begin
                pkt_q   <= pkt_d;
                order_q <= cnt_q;
                cnt_q   <= cnt_q + ORDER_W'(1);
            end
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
        end
    end

    assign rvfi_valid      = valid_q;
    assign rvfi_order      = order_q;
    assign rvfi_insn       = pkt_q.insn;
    assign rvfi_rs1_addr   = pkt_q.rs1_addr;
    assign rvfi_rs1_rdata  = pkt_q.rs1_rdata;
    assign rvfi_rs2_addr   = pkt_q.rs2_addr;
    assign rvfi_rs2_rdata  = pkt_q.rs2_rdata;
    assign rvfi_rd_addr    = pkt_q.rd_addr;
    assign rvfi_rd_wdata   = pkt_q.rd_wdata;
    assign err_overflow_o  = ovf_q;
    assign err_underflow_o = unf_q;

endmodule

// File: doc/rvfi_retire_packer.md
Name: rvfi_retire_packer

Overview:
Producer side of the RVFI retirement trace consumed by our register-consistency properties. Captures operand reads at issue (ID) and destination writes at writeback (WB) from an in-order core, and pairs them in program order. Emits one registered RVFI packet per retired instruction with a monotonically increasing order number. Sits inside ibex_top next to the core pipeline and drives the rvfi_* signals bound to the property checkers.

Parameters:
DEPTH, 4, number of issued-but-not-retired instructions held (power of two, >=2)
ORDER_W, 64, width of rvfi_order counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
id_valid_i  in  1  instruction issued this cycle
id_insn_i  in  32  instruction word
id_rs1_addr_i  in  5  rs1 index
id_rs1_rdata_i  in  32  rs1 value read at issue
id_rs2_addr_i  in  5  rs2 index
id_rs2_rdata_i  in  32  rs2 value read at issue
wb_valid_i  in  1  oldest outstanding instruction retires this cycle
wb_rd_addr_i  in  5  rd index (0 = no write)
wb_rd_wdata_i  in  32  rd value
flush_i  in  1  squash all outstanding, not-retiring instructions
rvfi_valid  out  1  packet valid
rvfi_order  out  ORDER_W  retirement index
rvfi_insn  out  32  instruction word
rvfi_rs1_addr  out  5  rs1 index
rvfi_rs1_rdata  out  32  rs1 value
rvfi_rs2_addr  out  5  rs2 index
rvfi_rs2_rdata  out  32  rs2 value
rvfi_rd_addr  out  5  rd index
rvfi_rd_wdata  out  32  rd value
occupancy_o  out  $clog2(DEPTH)+1  outstanding entries
err_overflow_o  out  1  sticky: issue dropped because queue full
err_underflow_o  out  1  sticky: writeback with queue empty

Behaviour:
- Reset (rst_ni low at a clock edge): all outputs 0, queue empty, order counter 0, sticky errors cleared. Reset mid-operation discards all entries; no packet is emitted on the cycle after reset.
- Issue: id_valid_i pushes {insn, rs1_addr, rs1_rdata, rs2_addr, rs2_rdata} at the queue tail.
- Writeback: wb_valid_i pops the head. Only entries present at the start of the cycle are eligible; a same-cycle issue cannot retire that cycle.
- Emit latency 1: on the edge after a pop, rvfi_valid=1 with head fields, wb rd fields, and rvfi_order = counter value; the counter then increments by 1 and wraps modulo 2^ORDER_W. rvfi_valid is 0 in all other cycles. rvfi_* fields hold their last values when rvfi_valid=0.
- x0 rules: rs1/rs2 rdata are forced to 0 when the corresponding addr is 0. rd_wdata is forced to 0 when rd_addr is 0.
- Full: id_valid_i with occupancy==DEPTH and no pop drops the issue and sets err_overflow_o. Full with simultaneous pop and push is legal; occupancy is unchanged.
- Empty: wb_valid_i with occupancy==0 sets err_underflow_o, emits nothing, and leaves the counter unchanged.
- Flush: the writeback pop is processed first and its packet is emitted normally. All remaining entries are then discarded, and a same-cycle id_valid_i is also discarded. After flush, occupancy=0. The order counter is not advanced for squashed entries.
- The sticky errors clear only on reset.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is a separate counter: +1 push, -1 pop, 0 when both or neither.

Decomposition:
- Package rvfi_pkg: typedef issue_entry_t (insn, rs1/rs2 addr+rdata), typedef rvfi_pkt_t, constants REG_ADDR_W=5, XLEN=32, X0=5'd0.
- Sub-module rvfi_issue_fifo: synchronous FIFO of issue_entry_t with push, pop, clear, full, empty, and count. The top level holds the order counter, x0 masking, output register, and sticky errors.

Test Plan:
- Issue addi x7 (rs1=x5=0x10); wb rd=7, wdata=0x15 one cycle later → next cycle rvfi_valid=1, order=0, rs1_rdata=0x10, rd_addr=7, rd_wdata=0x15.
- Issue 4 instructions back-to-back (DEPTH=4), then 4 wb → rvfi_valid for 4 consecutive cycles, orders 0..3, insn words in issue order, occupancy 4→0.
- Full queue plus a 5th id_valid with no wb → err_overflow_o=1, occupancy stays 4. Full plus id and wb in the same cycle → no error, occupancy stays 4.
- wb_valid_i with empty queue → err_underflow_o=1, rvfi_valid stays 0, next legal retirement gets order 0.
- 3 outstanding, flush_i with wb_valid_i (rd=x0, wdata=0xDEAD) and id_valid_i → one packet with rd_wdata=0, occupancy=0, next retirement order=1.
- Reset asserted with 2 outstanding → next cycle rvfi_valid=0, occupancy=0, order restarts at 0.
